// File: rtl/ivs_dma_pkg.sv
// Shared definitions for the IVS DMA read/write engines: FSM encoding, AXI constants, defaults.
package ivs_dma_pkg;

    localparam int DMA_DATA_W = 128;
    localparam int DMA_LEN_W  = 6;

    localparam logic [2:0] AXSIZE_16B = 3'b100;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_DONE
    } dma_state_e;

    // True when a burst of `beats` 16-byte beats starting at base_lo runs past a 4 KiB page.
    function automatic logic cross_4k(input logic [11:0] base_lo, input int unsigned beats);
        return (32'(base_lo) + beats * 32'd16) > 32'd4096;
    endfunction

endpackage

// File: rtl/ivs_dma_wbuf.sv
// One-entry registered W stage: holds a beat (data + last) until wready takes it.
module ivs_dma_wbuf
    import ivs_dma_pkg::*;
#(
    parameter int DATA_W = DMA_DATA_W
) (
    input  logic              aclk,
    input  logic              arst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              wready,
    output logic              wvalid,
    output logic [DATA_W-1:0] wdata,
    output logic              wlast,
    output logic              can_load
);

    assign can_load = !wvalid || wready;

    always_ff @(posedge aclk) begin
        if (arst) begin
            wvalid <= 1'b0;
            wdata  <= '0;
            wlast  <= 1'b0;
        end else if (load) begin
            wvalid <= 1'b1;
            wdata  <= load_data;
            wlast  <= load_last;
        end else if (wvalid && wready) begin
            wvalid <= 1'b0;
            wlast  <= 1'b0;
        end
    end

endmodule

// File: rtl/ivs_dma_wr.sv
// IVS DMA AXI write initiator: one AW, len+1 W beats from a valid/ready source, one B.
// Optional 4 KiB boundary reject enabled by defining IVS_DMA_WR_4K_CHK_EN.
//
//   state | meaning
//   IDLE  | waiting for dw_req; request fields latched on accept
//   ADDR  | awvalid up until awready (or straight to DONE on 4K reject)
//   DATA  | streaming source beats through the W register
//   RESP  | bready up, waiting for bvalid
//   DONE  | one-cycle dw_done / dw_err pulse
module ivs_dma_wr
    import ivs_dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = DMA_DATA_W,
    parameter int LEN_W  = DMA_LEN_W,
    parameter int ID_W   = 4
) (
    input  logic                aclk,
    input  logic                arst,
    input  logic                dw_req,
    input  logic [ADDR_W-1:0]   dw_base,
    input  logic [LEN_W-1:0]    dw_len,
    input  logic [ID_W-1:0]     dw_wid,
    output logic                dw_busy,
    output logic                dw_done,
    output logic                dw_err,
    input  logic                src_valid,
    input  logic [DATA_W-1:0]   src_data,
    output logic                src_ready,
    output logic                awvalid,
    input  logic                awready,
    output logic [ID_W-1:0]     awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [LEN_W-1:0]    awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awport,
    output logic [3:0]          awregion,
    output logic [3:0]          awqos,
    output logic [7:0]          awuser,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    input  logic                bvalid,
    output logic                bready,
    input  logic [ID_W-1:0]     bid,
    input  logic [1:0]          bresp
);

    dma_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [ID_W-1:0]   id_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              beats_left_q;
    logic              err_q;
    logic              rej_q;
    logic              chk_fail;
    logic              can_load;
    logic              load;

`ifdef IVS_DMA_WR_4K_CHK_EN
    assign chk_fail = cross_4k(dw_base[11:0], 32'(dw_len) + 32'd1);
`else
    assign chk_fail = 1'b0;
`endif

    assign src_ready = (state_q == ST_DATA) && beats_left_q && can_load;
    assign load      = src_valid && src_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (dw_req) state_d = ST_ADDR;
            ST_ADDR: begin
                if (rej_q)        state_d = ST_DONE;
                else if (awready) state_d = ST_DATA;
            end
            ST_DATA: if (wvalid && wready && wlast) state_d = ST_RESP;
            ST_RESP: if (bvalid) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            id_q         <= '0;
            cnt_q        <= '0;
            beats_left_q <= 1'b0;
            err_q        <= 1'b0;
            rej_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && dw_req) begin
                base_q <= dw_base;
                len_q  <= dw_len;
                id_q   <= dw_wid;
                rej_q  <= chk_fail;
                err_q  <= chk_fail;
            end
            // Counter holds beats still to load minus one; beats_left stops loading at zero.
            if (state_q == ST_ADDR && awvalid && awready) begin
                cnt_q        <= len_q;
                beats_left_q <= 1'b1;
            end else if (load) begin
                if (cnt_q == '0) beats_left_q <= 1'b0;
                else             cnt_q        <= cnt_q - 1'b1;
            end
            if (state_q == ST_RESP && bvalid)
                err_q <= (bresp != RESP_OKAY) || (bid != id_q);
        end
    end

    ivs_dma_wbuf #(.DATA_W(DATA_W)) u_wbuf (
        .aclk      (aclk),
        .arst      (arst),
        .load      (load),
        .load_data (src_data),
        .load_last (cnt_q == '0),
        .wready    (wready),
        .wvalid    (wvalid),
        .wdata     (wdata),
        .wlast     (wlast),
        .can_load  (can_load)
    );

    assign awvalid  = (state_q == ST_ADDR) && !rej_q;
    assign awaddr   = base_q;
    assign awlen    = len_q;
    assign awid     = id_q;
    assign awsize   = AXSIZE_16B;
    assign awburst  = BURST_INCR;
    assign awlock   = 1'b0;
    assign awcache  = '0;
    assign awport   = '0;
    assign awregion = '0;
    assign awqos    = '0;
    assign awuser   = '0;
    assign wstrb    = '1;
    assign bready   = (state_q == ST_RESP);
    assign dw_busy  = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_RESP);
    assign dw_done  = (state_q == ST_DONE);
    assign dw_err   = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_ivs_dma_wr.sv
// Randomised bench for ivs_dma_wr: transaction-level model (source beat queue, expected AW/B) checked every cycle.
module tb_ivs_dma_wr;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int LEN_W  = 6;
    localparam int ID_W   = 4;

    logic                clk = 1'b0;
    logic                arst;
    logic                dw_req;
    logic [ADDR_W-1:0]   dw_base;
    logic [LEN_W-1:0]    dw_len;
    logic [ID_W-1:0]     dw_wid;
    logic                dw_busy, dw_done, dw_err;
    logic                src_valid;
    logic [DATA_W-1:0]   src_data;
    logic                src_ready;
    logic                awvalid, awready;
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [LEN_W-1:0]    awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awport;
    logic [3:0]          awregion;
    logic [3:0]          awqos;
    logic [7:0]          awuser;
    logic                wvalid, wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                bvalid, bready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;

    ivs_dma_wr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
        .aclk(clk), .arst(arst),
        .dw_req(dw_req), .dw_base(dw_base), .dw_len(dw_len), .dw_wid(dw_wid),
        .dw_busy(dw_busy), .dw_done(dw_done), .dw_err(dw_err),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awport(awport),
        .awregion(awregion), .awqos(awqos), .awuser(awuser),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Stimulus knobs (percent probabilities for the random slave/source).
    int          p_aw = 100, p_w = 100, p_src = 100, p_b = 100;
    bit          w_toggle = 0, src_fixed = 0, force_bid = 0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [3:0]  forced_bid = 4'd0;

    // Model of the transaction in flight.
    bit                in_flight = 0, aw_seen = 0, m_rej = 0, m_err = 0, got_done = 0;
    int                m_len = 0, req_cyc = 0, beats_in = 0, beats_out = 0, wlast_cnt = 0, aw_cnt = 0;
    logic [ADDR_W-1:0] m_base = '0;
    logic [ID_W-1:0]   m_id = '0;
    logic [DATA_W-1:0] q[$];
    int                last_lat = 0, last_beats = 0;
    bit                last_err = 0;
    logic [ADDR_W-1:0] last_awaddr = '0;
    logic [DATA_W-1:0] last_wdata = '0;

    bit                aw_stall = 0, w_stall = 0;
    logic [ADDR_W-1:0] p_awaddr;
    logic [LEN_W-1:0]  p_awlen;
    logic [ID_W-1:0]   p_awid;
    logic [DATA_W-1:0] p_wdata;
    logic              p_wlast;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic bad(input string name);
        n_chk++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic bit crosses(input logic [ADDR_W-1:0] base, input int len);
`ifdef IVS_DMA_WR_4K_CHK_EN
        return (int'(base[11:0]) + (len + 1) * 16) > 4096;
`else
        return 1'b0;
`endif
    endfunction

    // Random slave and source, driven just after each rising edge.
    initial begin
        awready = 0; wready = 0; src_valid = 0; src_data = '0; bvalid = 0; bid = '0; bresp = '0;
        forever begin
            @(posedge clk);
            #1;
            awready   = ($urandom_range(99) < p_aw);
            wready    = w_toggle ? cyc[0] : ($urandom_range(99) < p_w);
            src_valid = ($urandom_range(99) < p_src);
            src_data  = src_fixed ? {16{8'hA5}} : {$urandom(), $urandom(), $urandom(), $urandom()};
            bvalid    = ($urandom_range(99) < p_b);
            bid       = force_bid ? forced_bid : m_id;
            bresp     = cfg_bresp;
        end
    end

    // Compare process: everything observed mid-cycle equals what the DUT sees at the next edge.
    always @(negedge clk) begin
        cyc++;
        if (arst) begin
            in_flight = 0;
            q.delete();
            aw_stall = 0;
            w_stall = 0;
        end else begin
            if (!in_flight) begin
                chk("idle_awvalid", awvalid, 0);
                chk("idle_wvalid", wvalid, 0);
                chk("idle_src_ready", src_ready, 0);
                chk("idle_bready", bready, 0);
            end
            if (aw_stall) begin
                chk("aw_hold_valid", awvalid, 1);
                chk("aw_hold_addr", awaddr, p_awaddr);
                chk("aw_hold_len", awlen, p_awlen);
                chk("aw_hold_id", awid, p_awid);
            end
            if (w_stall) begin
                chk("w_hold_valid", wvalid, 1);
                chk("w_hold_data", wdata, p_wdata);
                chk("w_hold_last", wlast, p_wlast);
            end
            if (in_flight) begin
                if (m_rej) begin
                    chk("rej_awvalid", awvalid, 0);
                    chk("rej_wvalid", wvalid, 0);
                end
                if (awvalid) begin
                    chk("awaddr", awaddr, m_base);
                    chk("awlen", awlen, m_len);
                    chk("awid", awid, m_id);
                    chk("awsize", awsize, 3'b100);
                    chk("awburst", awburst, 2'b01);
                    chk("aw_consts", {awlock, awcache, awport, awregion, awqos, awuser}, 0);
                end
                if (!aw_seen) begin
                    chk("pre_aw_wvalid", wvalid, 0);
                    chk("pre_aw_src_ready", src_ready, 0);
                end
                if (awvalid && awready) begin
                    aw_seen = 1;
                    aw_cnt++;
                    last_awaddr = awaddr;
                end
                if (src_valid && src_ready) begin
                    q.push_back(src_data);
                    beats_in++;
                    chk("src_overrun", beats_in <= m_len + 1, 1);
                end
                if (wvalid) chk("wstrb", wstrb, {(DATA_W/8){1'b1}});
                if (wvalid && wready) begin
                    if (q.size() == 0) bad("w_beat_without_source");
                    else chk("wdata_order", wdata, q.pop_front());
                    chk("wlast_pos", wlast, beats_out == m_len);
                    if (wlast) wlast_cnt++;
                    beats_out++;
                    last_wdata = wdata;
                end
                if (dw_done) begin
                    chk("dw_err", dw_err, m_err);
                    chk("dw_busy_in_done", dw_busy, 0);
                    chk("beat_count", beats_out, m_rej ? 0 : m_len + 1);
                    last_lat   = cyc - req_cyc;
                    last_err   = dw_err;
                    last_beats = beats_out;
                    in_flight  = 0;
                    got_done   = 1;
                end else begin
                    chk("busy_in_flight", dw_busy, 1);
                end
            end else if (dw_done) begin
                bad("unexpected_dw_done");
            end
            if (dw_req && !dw_busy && !dw_done && !in_flight) begin
                in_flight = 1; aw_seen = 0; beats_in = 0; beats_out = 0; wlast_cnt = 0; aw_cnt = 0;
                q.delete();
                m_base = dw_base; m_len = int'(dw_len); m_id = dw_wid; req_cyc = cyc;
                m_rej  = crosses(dw_base, int'(dw_len));
                m_err  = m_rej || (cfg_bresp != 2'b00) || (force_bid && forced_bid != dw_wid);
            end
            aw_stall = awvalid && !awready;
            p_awaddr = awaddr; p_awlen = awlen; p_awid = awid;
            w_stall  = wvalid && !wready;
            p_wdata  = wdata; p_wlast = wlast;
        end
    end

    task automatic start_req(input logic [ADDR_W-1:0] base, input int len, input logic [ID_W-1:0] id);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((dw_busy || dw_done || in_flight) && n < 3000);
        if (n >= 3000) bad("idle_timeout");
        got_done = 0;
        @(posedge clk); #1;
        dw_req = 1; dw_base = base; dw_len = LEN_W'(len); dw_wid = id;
        @(posedge clk); #1;
        dw_req = 0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!got_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!got_done) bad("done_timeout");
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_awvalid"}, awvalid, 0);
        chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_wlast"}, wlast, 0);
        chk({tag, "_bready"}, bready, 0);
        chk({tag, "_src_ready"}, src_ready, 0);
        chk({tag, "_dw_busy"}, dw_busy, 0);
        chk({tag, "_dw_done"}, dw_done, 0);
        chk({tag, "_dw_err"}, dw_err, 0);
    endtask

    initial begin
        int n;
        arst = 1; dw_req = 0; dw_base = '0; dw_len = '0; dw_wid = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        arst = 0;

        // Single beat, everything ready: 5-cycle turnaround.
        src_fixed = 1;
        start_req(32'h1000, 0, 4'd3);
        wait_done();
        chk("t1_latency", last_lat, 5);
        chk("t1_err", last_err, 0);
        chk("t1_awaddr", last_awaddr, 32'h1000);
        chk("t1_wdata", last_wdata, {16{8'hA5}});
        chk("t1_beats", last_beats, 1);
        src_fixed = 0;

        // 64 beats against a toggling wready.
        w_toggle = 1;
        start_req(32'h2000, 63, 4'd7);
        wait_done();
        chk("t2_beats", last_beats, 64);
        chk("t2_wlast_cnt", wlast_cnt, 1);
        w_toggle = 0;

        // awready held low.
        p_aw = 0;
        start_req(32'h0000_4000, 5, 4'd1);
        repeat (10) @(negedge clk);
        chk("t3_awvalid_held", awvalid, 1);
        chk("t3_no_aw_hs", aw_cnt, 0);
        chk("t3_no_src_ready", src_ready, 0);
        p_aw = 100;
        wait_done();
        chk("t3_err", last_err, 0);

        // Error responses.
        cfg_bresp = 2'b10;
        start_req(32'h5000, 2, 4'd3);
        wait_done();
        chk("t4_bresp_err", last_err, 1);
        cfg_bresp = 2'b00;
        force_bid = 1; forced_bid = 4'd5;
        start_req(32'h5000, 2, 4'd3);
        wait_done();
        chk("t4_bid_err", last_err, 1);
        force_bid = 0;

        // dw_req pulsed mid-DATA with different fields.
        p_src = 40;
        start_req(32'h6000, 10, 4'd2);
        n = 0;
        while (!(aw_seen && beats_out < 5 && in_flight) && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        dw_req = 1; dw_base = 32'h7770; dw_len = 6'd1; dw_wid = 4'd9;
        @(posedge clk); #1;
        dw_req = 0;
        wait_done();
        chk("t5_beats", last_beats, 11);
        chk("t5_awaddr", last_awaddr, 32'h6000);
        p_src = 100;

        // Reset mid-DATA at beat 20, then a normal request.
        p_w = 60;
        start_req(32'h8000, 63, 4'd4);
        n = 0;
        while (beats_in < 20 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (beats_in < 20) bad("t6_beat20_timeout");
        @(posedge clk); #1;
        arst = 1;
        @(posedge clk); #1;
        check_all_zero("midreset");
        arst = 0;
        p_w = 100;
        start_req(32'h9000, 3, 4'd6);
        wait_done();
        chk("t6_after_reset_beats", last_beats, 4);
        chk("t6_after_reset_err", last_err, 0);

`ifdef IVS_DMA_WR_4K_CHK_EN
        start_req(32'h0FF0, 1, 4'd3);
        wait_done();
        chk("t7_4k_latency", last_lat, 2);
        chk("t7_4k_err", last_err, 1);
        chk("t7_4k_no_aw", aw_cnt, 0);
        start_req(32'h0FF0, 0, 4'd3);
        wait_done();
        chk("t7_edge_err", last_err, 0);
        chk("t7_edge_aw", aw_cnt, 1);
`endif

        // Random traffic.
        for (int t = 0; t < 25; t++) begin
            p_aw  = $urandom_range(100, 30);
            p_w   = $urandom_range(100, 30);
            p_src = $urandom_range(100, 30);
            p_b   = $urandom_range(100, 30);
            cfg_bresp  = ($urandom_range(3) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            force_bid  = ($urandom_range(4) == 0);
            forced_bid = 4'($urandom_range(15));
            start_req($urandom() & 32'hFFFF_FFF0, $urandom_range(63), 4'($urandom_range(15)));
            wait_done();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
